// File: rtl/pitch_sched_pkg.sv
// Shared types and sizing helpers for the pitch frame scheduler.
package pitch_sched_pkg;

    localparam int V_WIDTH_DEF  = 3;
    localparam int O_WIDTH_DEF  = 2;
    localparam int OE_WIDTH_DEF = 1;
    localparam int SLOT_W       = V_WIDTH_DEF + O_WIDTH_DEF + OE_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        SWEEP,
        DRAIN,
        KEYLD,
        KEYSTB
    } sched_state_e;

    typedef struct packed {
        logic              valid;
        logic [SLOT_W-1:0] slot;
    } slot_entry_t;

    function automatic int slots_f(input int vw, input int ew);
        return 1 << (vw + ew);
    endfunction

    function automatic int pairs_f(input int voices, input int oscs);
        return voices * oscs;
    endfunction

endpackage

// File: rtl/pitch_slot_delay.sv
// Fixed-latency shift register that carries each slot address alongside the
// datapath so the result can be written back to the slot that produced it.
module pitch_slot_delay
    import pitch_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        sCLK_XVXOSC,
    input  logic        reset_reg_N,
    input  slot_entry_t push_i,
    output slot_entry_t tail_o
);

    slot_entry_t line_q [DEPTH];

    // Clearing every stage on reset is what prevents partial writes after release.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign tail_o = line_q[DEPTH-1];

endmodule

// File: rtl/pitch_sweep_sched.sv
// Frame scheduler: sweeps every voice/osc slot, writes aligned pitch results,
// and inserts key updates only between frames.
module pitch_sweep_sched
    import pitch_sched_pkg::*;
#(
    parameter int VOICES   = 8,
    parameter int V_OSC    = 4,
    parameter int V_WIDTH  = V_WIDTH_DEF,
    parameter int O_WIDTH  = O_WIDTH_DEF,
    parameter int OE_WIDTH = OE_WIDTH_DEF,
    parameter int E_WIDTH  = O_WIDTH + OE_WIDTH,
    parameter int PIPE_LAT = 4
) (
    input  logic                        sCLK_XVXOSC,
    input  logic                        reset_reg_N,
    input  logic                        run_en,
    output logic [V_WIDTH+E_WIDTH-1:0]  xxxx,
    input  logic [23:0]                 osc_pitch_val,
    output logic                        pitch_wr_en,
    output logic [V_WIDTH+O_WIDTH-1:0]  pitch_wr_adr,
    output logic [23:0]                 pitch_wr_data,
    input  logic                        key_req,
    input  logic [V_WIDTH-1:0]          key_adr,
    input  logic [7:0]                  key_val,
    output logic                        key_ack,
    output logic [V_WIDTH-1:0]          cur_key_adr,
    output logic [7:0]                  cur_key_val,
    output logic                        note_on,
    output logic                        frame_done
);

    localparam int SW     = V_WIDTH + E_WIDTH;
    localparam int SLOTS  = slots_f(V_WIDTH, E_WIDTH);
    localparam int VCOUNT = 1 << V_WIDTH;
    localparam int OCOUNT = 1 << O_WIDTH;

    localparam logic [SW-1:0]     SLOT_LAST  = SW'(SLOTS - 1);
    localparam logic [3:0]        LAT_LAST   = 4'(PIPE_LAT - 1);
    localparam logic [VCOUNT-1:0] VOICE_MASK = VCOUNT'((64'd1 << VOICES) - 64'd1);
    localparam logic [OCOUNT-1:0] OSC_MASK   = OCOUNT'((64'd1 << V_OSC) - 64'd1);

    sched_state_e     state_q;
    logic [SW-1:0]    slot_q;
    logic [SW-1:0]    slot_d;
    logic [3:0]       drain_q;
    logic             note_on_q;
    logic             key_ack_q;
    logic             frame_done_q;
    logic [V_WIDTH-1:0] cur_key_adr_q;
    logic [7:0]       cur_key_val_q;

    slot_entry_t      push;
    slot_entry_t      tail;
    logic [SW-1:0]    tail_slot;
    logic [V_WIDTH-1:0] tail_voice;
    logic [O_WIDTH-1:0] tail_osc;

    assign slot_d = slot_q + 1'b1;

    // Strobes are computed one cycle ahead so every output comes straight from a flop.
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            drain_q       <= '0;
            note_on_q     <= 1'b0;
            key_ack_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            cur_key_adr_q <= '0;
            cur_key_val_q <= 8'hFF;
        end else begin
            note_on_q    <= 1'b0;
            key_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    slot_q <= '0;
                    if (key_req) begin
                        state_q <= KEYLD;
                    end else if (run_en) begin
                        state_q <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (slot_q == SLOT_LAST) begin
                        slot_q       <= '0;
                        drain_q      <= '0;
                        state_q      <= DRAIN;
                        frame_done_q <= (PIPE_LAT == 1);
                    end else begin
                        slot_q <= slot_d;
                    end
                end
                DRAIN: begin
                    slot_q <= '0;
                    if (drain_q == LAT_LAST) begin
                        if (key_req) begin
                            state_q <= KEYLD;
                        end else if (run_en) begin
                            state_q <= SWEEP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        drain_q      <= drain_q + 4'd1;
                        frame_done_q <= ((drain_q + 4'd1) == LAT_LAST);
                    end
                end
                KEYLD: begin
                    cur_key_adr_q <= key_adr;
                    cur_key_val_q <= key_val;
                    note_on_q     <= 1'b1;
                    key_ack_q     <= 1'b1;
                    state_q       <= KEYSTB;
                end
                KEYSTB: begin
                    state_q <= run_en ? SWEEP : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign push.valid = (state_q == SWEEP);
    assign push.slot  = SLOT_W'(slot_q);

    pitch_slot_delay #(
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .sCLK_XVXOSC (sCLK_XVXOSC),
        .reset_reg_N (reset_reg_N),
        .push_i      (push),
        .tail_o      (tail)
    );

    // Only the last sub-slot of a populated voice/osc pair carries the final pitch word.
    assign tail_slot  = SW'(tail.slot);
    assign tail_voice = tail_slot[SW-1 -: V_WIDTH];
    assign tail_osc   = tail_slot[OE_WIDTH +: O_WIDTH];

    assign pitch_wr_en   = tail.valid & (&tail_slot[OE_WIDTH-1:0])
                         & VOICE_MASK[tail_voice] & OSC_MASK[tail_osc];
    assign pitch_wr_adr  = tail_slot[SW-1:OE_WIDTH];
    assign pitch_wr_data = osc_pitch_val;

    assign xxxx        = slot_q;
    assign key_ack     = key_ack_q;
    assign note_on     = note_on_q;
    assign frame_done  = frame_done_q;
    assign cur_key_adr = cur_key_adr_q;
    assign cur_key_val = cur_key_val_q;

endmodule

// File: tb/tb_pitch_sweep_sched.sv
// Scoreboard bench: expected writes and strobes are queued as stimulus is
// driven and matched against the DUT cycle by cycle.
module tb_pitch_sweep_sched;

    typedef struct {
        int          cyc;
        logic [4:0]  adr;
        logic [23:0] data;
    } wrExp_t;

    typedef struct {
        int          cyc;
        logic        fd;
        logic        non;
        logic [2:0]  kadr;
        logic [7:0]  kval;
    } stbExp_t;

    logic        clk    = 1'b0;
    logic        rstN   = 1'b0;
    logic        runEn  = 1'b0;
    logic        runEn1 = 1'b0;
    logic        keyReq = 1'b0;
    logic [2:0]  keyAdr = 3'd0;
    logic [7:0]  keyVal = 8'd0;
    logic [23:0] oscPitch;
    int          cyc    = 0;
    int          total  = 0;
    int          bad    = 0;

    logic [5:0]  xxxx, xxxx1;
    logic        wrEn, wrEn1, keyAck, keyAck1, noteOn, noteOn1, frameDone, frameDone1;
    logic [4:0]  wrAdr, wrAdr1;
    logic [23:0] wrData, wrData1;
    logic [2:0]  curAdr, curAdr1;
    logic [7:0]  curVal, curVal1;

    wrExp_t  wq[$];
    wrExp_t  wq1[$];
    stbExp_t sq[$];
    stbExp_t sq1[$];

    function automatic logic [23:0] oscOf(input int c);
        return 24'(c * 3 + 7);
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign oscPitch = oscOf(cyc);

    pitch_sweep_sched dut (
        .sCLK_XVXOSC(clk), .reset_reg_N(rstN), .run_en(runEn), .xxxx(xxxx),
        .osc_pitch_val(oscPitch), .pitch_wr_en(wrEn), .pitch_wr_adr(wrAdr),
        .pitch_wr_data(wrData), .key_req(keyReq), .key_adr(keyAdr), .key_val(keyVal),
        .key_ack(keyAck), .cur_key_adr(curAdr), .cur_key_val(curVal),
        .note_on(noteOn), .frame_done(frameDone)
    );

    pitch_sweep_sched #(.PIPE_LAT(1)) dut1 (
        .sCLK_XVXOSC(clk), .reset_reg_N(rstN), .run_en(runEn1), .xxxx(xxxx1),
        .osc_pitch_val(oscPitch), .pitch_wr_en(wrEn1), .pitch_wr_adr(wrAdr1),
        .pitch_wr_data(wrData1), .key_req(1'b0), .key_adr(3'd0), .key_val(8'd0),
        .key_ack(keyAck1), .cur_key_adr(curAdr1), .cur_key_val(curVal1),
        .note_on(noteOn1), .frame_done(frameDone1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cyc=%0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic waitTo(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic applyStimulus(input int s);
        for (int k = 0; k < 32; k++) begin
            wq.push_back('{s + 2*k + 5, 5'(k), oscOf(s + 2*k + 5)});
        end
        sq.push_back('{s + 67, 1'b1, 1'b0, 3'd0, 8'd0});
    endtask

    task automatic applyStimulus1(input int s);
        for (int k = 0; k < 32; k++) begin
            wq1.push_back('{s + 2*k + 2, 5'(k), oscOf(s + 2*k + 2)});
        end
        sq1.push_back('{s + 64, 1'b1, 1'b0, 3'd0, 8'd0});
    endtask

    // Default-latency instance: writes plus frame/key strobes.
    always @(negedge clk) begin : mon0
        wrExp_t  we;
        stbExp_t se;
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            we = wq.pop_front();
            checkOutput("wr_en", 32'(wrEn), 32'd1);
            checkOutput("wr_adr", 32'(wrAdr), 32'(we.adr));
            checkOutput("wr_data", 32'(wrData), 32'(we.data));
        end else if (wrEn !== 1'b0) begin
            checkOutput("wr_stray", 32'(wrEn), 32'd0);
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            se = sq.pop_front();
            checkOutput("frame_done", 32'(frameDone), 32'(se.fd));
            checkOutput("note_on", 32'(noteOn), 32'(se.non));
            checkOutput("key_ack", 32'(keyAck), 32'(se.non));
            if (se.non) begin
                checkOutput("cur_key_adr", 32'(curAdr), 32'(se.kadr));
                checkOutput("cur_key_val", 32'(curVal), 32'(se.kval));
            end
        end else if ({noteOn, keyAck, frameDone} !== 3'b000) begin
            checkOutput("strobe_stray", 32'({noteOn, keyAck, frameDone}), 32'd0);
        end
    end

    // Single-cycle-latency instance: writes and frame_done only.
    always @(negedge clk) begin : mon1
        wrExp_t  we;
        stbExp_t se;
        if (wq1.size() > 0 && wq1[0].cyc == cyc) begin
            we = wq1.pop_front();
            checkOutput("lat1_wr_en", 32'(wrEn1), 32'd1);
            checkOutput("lat1_wr_adr", 32'(wrAdr1), 32'(we.adr));
            checkOutput("lat1_wr_data", 32'(wrData1), 32'(we.data));
        end else if (wrEn1 !== 1'b0) begin
            checkOutput("lat1_wr_stray", 32'(wrEn1), 32'd0);
        end
        if (sq1.size() > 0 && sq1[0].cyc == cyc) begin
            se = sq1.pop_front();
            checkOutput("lat1_frame_done", 32'(frameDone1), 32'(se.fd));
        end else if ({noteOn1, keyAck1, frameDone1} !== 3'b000) begin
            checkOutput("lat1_strobe_stray", 32'({noteOn1, keyAck1, frameDone1}), 32'd0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int s, s2, s3, s4, s5, t;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_xxxx", 32'(xxxx), 32'd0);
        checkOutput("rst_wr_en", 32'(wrEn), 32'd0);
        checkOutput("rst_note_on", 32'(noteOn), 32'd0);
        checkOutput("rst_key_ack", 32'(keyAck), 32'd0);
        checkOutput("rst_frame_done", 32'(frameDone), 32'd0);
        checkOutput("rst_cur_adr", 32'(curAdr), 32'd0);
        checkOutput("rst_cur_val", 32'(curVal), 32'hFF);

        // Continuous sweep with a key request arriving mid-frame
        rstN  = 1'b1;
        runEn = 1'b1;
        s = cyc + 1;
        applyStimulus(s);
        for (int i = 0; i < 64; i++) begin
            waitTo(s + i);
            checkOutput("sweep_xxxx", 32'(xxxx), 32'(i));
            if (i == 20) begin
                keyReq = 1'b1;
                keyAdr = 3'd5;
                keyVal = 8'd60;
                sq.push_back('{s + 69, 1'b0, 1'b1, 3'd5, 8'd60});
            end
        end
        waitTo(s + 64);
        checkOutput("drain_xxxx", 32'(xxxx), 32'd0);
        waitTo(s + 68);
        checkOutput("keyld_cur_val", 32'(curVal), 32'hFF);
        waitTo(s + 69);
        keyReq = 1'b0;
        s2 = s + 70;
        applyStimulus(s2);
        waitTo(s2);
        checkOutput("sweep2_xxxx0", 32'(xxxx), 32'd0);
        waitTo(s2 + 1);
        checkOutput("sweep2_xxxx1", 32'(xxxx), 32'd1);
        checkOutput("held_cur_adr", 32'(curAdr), 32'd5);
        checkOutput("held_cur_val", 32'(curVal), 32'd60);

        // run_en drops mid-sweep: frame completes then idles
        waitTo(s2 + 30);
        runEn = 1'b0;
        for (int i = 68; i < 76; i++) begin
            waitTo(s2 + i);
            checkOutput("idle_xxxx", 32'(xxxx), 32'd0);
        end

        // Key event from IDLE with sweeping disabled
        t = cyc;
        keyReq = 1'b1;
        keyAdr = 3'd7;
        keyVal = 8'h40;
        sq.push_back('{t + 2, 1'b0, 1'b1, 3'd7, 8'h40});
        waitTo(t + 1);
        checkOutput("idle_keyld_val", 32'(curVal), 32'd60);
        waitTo(t + 2);
        keyReq = 1'b0;
        waitTo(t + 3);
        checkOutput("idle_key_adr", 32'(curAdr), 32'd7);
        checkOutput("idle_key_val", 32'(curVal), 32'h40);
        waitTo(t + 6);
        checkOutput("idle_after_key_xxxx", 32'(xxxx), 32'd0);

        // Reset pulse mid-frame
        runEn = 1'b1;
        s3 = cyc + 1;
        applyStimulus(s3);
        waitTo(s3 + 40);
        checkOutput("pre_rst_xxxx", 32'(xxxx), 32'd40);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_xxxx", 32'(xxxx), 32'd0);
        checkOutput("midrst_wr_en", 32'(wrEn), 32'd0);
        checkOutput("midrst_cur_adr", 32'(curAdr), 32'd0);
        checkOutput("midrst_cur_val", 32'(curVal), 32'hFF);
        checkOutput("midrst_strobes", 32'({noteOn, keyAck, frameDone}), 32'd0);
        wq.delete();
        sq.delete();
        waitTo(s3 + 43);
        rstN = 1'b1;
        s4 = cyc + 1;
        applyStimulus(s4);
        for (int i = 0; i < 4; i++) begin
            waitTo(s4 + i);
            checkOutput("restart_xxxx", 32'(xxxx), 32'(i));
        end
        waitTo(s4 + 30);
        runEn = 1'b0;
        waitTo(s4 + 72);

        // Single-cycle pipeline latency instance
        runEn1 = 1'b1;
        s5 = cyc + 1;
        applyStimulus1(s5);
        waitTo(s5 + 63);
        checkOutput("lat1_last_slot", 32'(xxxx1), 32'd63);
        waitTo(s5 + 64);
        checkOutput("lat1_drain_xxxx", 32'(xxxx1), 32'd0);
        applyStimulus1(s5 + 65);
        waitTo(s5 + 65);
        checkOutput("lat1_restart0", 32'(xxxx1), 32'd0);
        waitTo(s5 + 66);
        checkOutput("lat1_restart1", 32'(xxxx1), 32'd1);
        runEn1 = 1'b0;
        waitTo(s5 + 65 + 70);
        checkOutput("lat1_idle_xxxx", 32'(xxxx1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pitch_sweep_sched.md
Name: pitch_sweep_sched

Overview:
Frame scheduler for the pitch datapath. Sweeps the voice/oscillator slot index `xxxx` across every slot and aligns the datapath's `osc_pitch_val` result (fixed latency PIPE_LAT) with its slot address. Writes one 24-bit pitch word per voice/osc into the downstream phase-increment register file. Serialises key events into `note_on` strobes between sweeps, so `cur_key_*` and `rkey_val` never change mid-frame.

Parameters:
- VOICES, 8, number of voices.
- V_OSC, 4, oscillators per voice.
- V_WIDTH, 3, voice index width.
- O_WIDTH, 2, oscillator index width.
- OE_WIDTH, 1, sub-slot (extension) width.
- E_WIDTH, O_WIDTH+OE_WIDTH, osc+sub-slot width.
- PIPE_LAT, 4, cycles from `xxxx` presented to matching `osc_pitch_val`; legal range is 1..15.

Ports:
- sCLK_XVXOSC  in  1  clock.
- reset_reg_N  in  1  asynchronous, active-low reset.
- run_en  in  1  enables continuous sweeping.
- xxxx  out  V_WIDTH+E_WIDTH  slot index to the datapath: {voice, osc, sub}.
- osc_pitch_val  in  24  datapath result.
- pitch_wr_en  out  1  register-file write strobe.
- pitch_wr_adr  out  V_WIDTH+O_WIDTH  write address {voice, osc}.
- pitch_wr_data  out  24  write data.
- key_req  in  1  key event pending; held until ack.
- key_adr  in  V_WIDTH  voice for the event; stable while key_req is high.
- key_val  in  8  key value; stable while key_req is high.
- key_ack  out  1  one-cycle acknowledge.
- cur_key_adr  out  V_WIDTH  key address to the datapath.
- cur_key_val  out  8  key value to the datapath.
- note_on  out  1  one-cycle key-write strobe; the datapath samples on its rising edge.
- frame_done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset values (asynchronous): state=IDLE, xxxx=0, delay line all invalid, pitch_wr_en=0, key_ack=0, note_on=0, frame_done=0, cur_key_adr=0, cur_key_val=8'hFF.
- SLOTS = 2^(V_WIDTH+E_WIDTH), which is 64 at default parameters.
- FSM states: IDLE, SWEEP, DRAIN, KEYLD, KEYSTB.
- IDLE:
  - key_req=1 → KEYLD (takes priority).
  - else run_en=1 → SWEEP.
  - xxxx is held at 0.
- SWEEP:
  - xxxx increments by 1 every cycle, starting from 0.
  - Each cycle pushes {valid=1, xxxx} into the delay line.
  - On the cycle xxxx=SLOTS-1: next xxxx=0, next state DRAIN.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles; pushes invalid entries; xxxx held at 0.
  - frame_done=1 on the last DRAIN cycle.
  - Exit: key_req=1 → KEYLD; else run_en=1 → SWEEP; else → IDLE.
- KEYLD (1 cycle): cur_key_adr←key_adr and cur_key_val←key_val, registered at the end of the cycle.
- KEYSTB (1 cycle):
  - note_on=1 and key_ack=1; cur_key_* are already stable.
  - Next state: run_en=1 → SWEEP, else IDLE.
- At most one key event is serviced per frame boundary; further requests wait for the next boundary.
- Write path:
  - Delay line is PIPE_LAT deep, so the tail holds the entry pushed PIPE_LAT cycles earlier.
  - pitch_wr_en = tail.valid & (tail sub-bits all ones). This is combinational from registered state.
  - pitch_wr_adr = tail {voice, osc} bits.
  - pitch_wr_data = osc_pitch_val, passed through the same cycle.
- Per frame: exactly VOICES*V_OSC writes (32 at default), addresses ascending 0..31. The last write lands in the last DRAIN cycle, coincident with frame_done.
- Frame period with run_en held high:
  - SLOTS+PIPE_LAT cycles without a key event (68 at default).
  - +2 cycles with a key event (70 at default).
- Boundary conditions:
  - run_en dropping mid-SWEEP or mid-DRAIN: the frame completes, including its pending writes.
  - key_req rising mid-frame: no effect until the DRAIN exit.
  - key_req dropped by the requester before ack: a protocol violation; behaviour is undefined.
  - Reset mid-frame: aborts immediately; the delay line is cleared, so no partial writes occur after release.
  - note_on never asserts during SWEEP or DRAIN.

Decomposition:
- Package pitch_sched_pkg:
  - state enum (IDLE, SWEEP, DRAIN, KEYLD, KEYSTB).
  - SLOTS and pair-count localparam functions.
  - slot-entry struct {valid, slot}.
- Sub-module pitch_slot_delay: parameterised PIPE_LAT-deep shift register of slot entries, asynchronously cleared.

Test Plan:
1. Reset release, run_en=1, osc_pitch_val=cycle counter:
   - xxxx runs 0..63 on cycles 0..63.
   - pitch_wr_en is high on cycles 5,7,…,67 with addresses 0..31 and data equal to that cycle's osc_pitch_val.
   - frame_done on cycle 67; next xxxx=0 sweep starts on cycle 68.
2. key_req at cycle 20 with key_adr=5, key_val=60:
   - cur_key_adr=5 and cur_key_val=60 from cycle 69.
   - note_on=1 and key_ack=1 on cycle 69 only.
   - next sweep starts at cycle 70.
3. run_en deasserted at cycle 30: remaining writes complete, frame_done at 67, then IDLE with xxxx=0 and no further writes.
4. IDLE with run_en=0 and key_req for adr=7, val=8'h40: KEYLD then KEYSTB with note_on on the second cycle, then back to IDLE.
5. reset_reg_N pulsed low at cycle 40:
   - all outputs return to reset values immediately.
   - after release with run_en=1, the sweep restarts from 0 with no stale writes.
6. PIPE_LAT=1 build: frame period 65; write for slot n=2k+1 appears at cycle n+1; frame_done at cycle 64.
